// File: rtl/mem_load_readback.sv
// mem_load_readback: writes an incoming word stream to memory from START_ADDR, then
// reads it back in bursts through a 2-deep FIFO onto a backpressured output stream.
module mem_load_readback #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000,
   parameter int COUNT_WIDTH = 18
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [1:0]             burst_size,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   in_last,
   output logic [ADDR_WIDTH-1:0]  mem_address,
   output logic [DATA_WIDTH-1:0]  mem_data_in,
   output logic [1:0]             mem_access_size,
   output logic                   mem_rw,
   output logic                   mem_enable,
   input  logic                   mem_busy,
   input  logic [DATA_WIDTH-1:0]  mem_data_out,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] words_loaded
);
   typedef enum logic [1:0] {IDLE, LOAD, READ, DONE} state_t;
   localparam logic [COUNT_WIDTH-1:0] MAX = '1;
   state_t state, state_nx;
   logic [1:0] bsize, cur_code;
   logic [ADDR_WIDTH-1:0] addr;
   logic [COUNT_WIDTH-1:0] count, rd_left;
   logic [4:0] beat_left, blen;
   logic inflight, wr_ptr, rd_ptr;
   logic [1:0] fifo_count;
   logic [DATA_WIDTH-1:0] fifo [2];
   logic wr_acc, rd_acc, last_acc, new_burst, burst_ok, push, pop, drained;
   always_comb begin
      blen = bsize == 2'd0 ? 5'd1 : bsize == 2'd1 ? 5'd4 : bsize == 2'd2 ? 5'd8 : 5'd16;
      burst_ok = rd_left >= COUNT_WIDTH'(blen);
      new_burst = beat_left == 5'd0;
      in_ready = state == LOAD && !mem_busy && count != MAX;
      wr_acc = in_valid && in_ready;
      last_acc = wr_acc && (in_last || count == MAX - 1'b1);
      mem_enable = wr_acc || (state == READ && rd_left != '0 && (fifo_count + {1'b0, inflight}) < 2'd2);
      rd_acc = state == READ && mem_enable && !mem_busy;
      mem_rw = state == READ;
      // a burst only opens when enough words remain; the tail goes out as single beats
      mem_access_size = state != READ ? 2'd0 : !new_burst ? cur_code : burst_ok ? bsize : 2'd0;
      mem_data_in = state == LOAD ? in_data : '0;
      mem_address = addr;
      push = inflight;
      out_valid = fifo_count != 2'd0;
      pop = out_valid && out_ready;
      // when empty, the slot behind rd_ptr still holds the last word handed out
      out_data = fifo[out_valid ? rd_ptr : ~rd_ptr];
      drained = rd_left == '0 && !inflight && fifo_count == 2'd0;
      done = state == DONE;
      words_loaded = count;
      state_nx = state;
      case (state)
         IDLE: state_nx = start ? LOAD : IDLE;
         LOAD: state_nx = last_acc ? READ : LOAD;
         READ: state_nx = drained ? DONE : READ;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bsize <= '0;
         cur_code <= '0;
         addr <= '0;
         count <= '0;
         rd_left <= '0;
         beat_left <= '0;
         inflight <= 1'b0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         fifo_count <= '0;
         fifo[0] <= '0;
         fifo[1] <= '0;
      end else begin
         if (state == IDLE && start) begin
            bsize <= burst_size;
            addr <= START_ADDR;
            count <= '0;
            beat_left <= '0;
         end
         if (wr_acc) begin
            addr <= last_acc ? START_ADDR : addr + ADDR_WIDTH'(4);
            count <= count + 1'b1;
            if (last_acc) rd_left <= count + 1'b1;
         end
         if (rd_acc) begin
            addr <= addr + ADDR_WIDTH'(4);
            rd_left <= rd_left - 1'b1;
            if (new_burst) begin
               cur_code <= burst_ok ? bsize : 2'd0;
               beat_left <= burst_ok ? blen - 5'd1 : 5'd0;
            end else beat_left <= beat_left - 5'd1;
         end
         inflight <= rd_acc;
         if (push) begin
            fifo[wr_ptr] <= mem_data_out;
            wr_ptr <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: tb/tb_mem_load_readback.sv
// tb_mem_load_readback: directed load/readback runs against a behavioural memory with
// optional random stalls; checks addresses, access codes, data order and done pulses.
module tb_mem_load_readback;
   logic clock = 1'b0, reset_n = 1'b0, start = 1'b0;
   logic [1:0] burst_size = '0;
   logic in_valid = 1'b0, in_last = 1'b0, in_ready;
   logic [31:0] in_data = '0;
   logic [31:0] mem_address, mem_data_in, out_data;
   logic [31:0] mem_data_out = '0;
   logic [1:0] mem_access_size;
   logic mem_rw, mem_enable, out_valid, done;
   logic mem_busy = 1'b0, out_ready = 1'b1;
   logic [17:0] words_loaded;
   int total = 0, bad = 0, done_cnt = 0, max_out = 0;
   bit busy_rand = 0, rd_pend = 0;
   logic [31:0] rd_val;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] wa[$], wd[$], ra[$], rc[$], outq[$];

   mem_load_readback dut (
      .clock(clock), .reset_n(reset_n), .start(start), .burst_size(burst_size),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_access_size(mem_access_size),
      .mem_rw(mem_rw), .mem_enable(mem_enable), .mem_busy(mem_busy), .mem_data_out(mem_data_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .done(done),
      .words_loaded(words_loaded));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   // memory model and stream monitor, sampled mid-cycle
   always @(negedge clock) if (reset_n) begin
      if (mem_enable && !mem_busy) begin
         if (!mem_rw) begin
            mem[mem_address] = mem_data_in;
            wa.push_back(mem_address);
            wd.push_back(mem_data_in);
         end else begin
            ra.push_back(mem_address);
            rc.push_back(32'(mem_access_size));
            rd_pend = 1;
            rd_val = mem.exists(mem_address) ? mem[mem_address] : 32'hBAD0_BAD0;
         end
      end
      if (out_valid && out_ready) outq.push_back(out_data);
      if (done) done_cnt++;
      if (ra.size() - outq.size() > max_out) max_out = ra.size() - outq.size();
   end

   always @(posedge clock) begin
      #1;
      mem_data_out = rd_pend ? rd_val : 32'hDEAD_BEEF;
      rd_pend = 0;
      mem_busy = busy_rand ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   task automatic clear_log();
      wa.delete(); wd.delete(); ra.delete(); rc.delete(); outq.delete();
      done_cnt = 0; max_out = 0;
   endtask

   task automatic kick(input logic [1:0] bs);
      @(posedge clock); #2;
      start = 1'b1; burst_size = bs;
      @(posedge clock); #2;
      start = 1'b0;
   endtask

   task automatic send(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         int k;
         in_valid = 1'b1; in_data = base + 32'(i); in_last = (i == n - 1);
         for (k = 0; k < 200; k++) begin
            @(negedge clock);
            if (in_ready) break;
         end
         if (k == 200) chk("in_ready_timeout", 32'(i), 32'hFFFF_FFFF);
         @(posedge clock); #2;
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      for (k = 0; k < 3000; k++) begin
         @(negedge clock);
         if (done) break;
      end
      chk("done_seen", 32'(k < 3000), 32'd1);
      repeat (4) @(negedge clock);
   endtask

   task automatic check_run(input string t, input int n, input logic [31:0] base,
                            input logic [31:0] bcode, input int nfull);
      chk({t, "_nwr"}, 32'(wa.size()), 32'(n));
      chk({t, "_nrd"}, 32'(ra.size()), 32'(n));
      chk({t, "_nout"}, 32'(outq.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < wa.size()) begin
            chk($sformatf("%s_wa%0d", t, i), wa[i], 32'h8002_0000 + 32'(4 * i));
            chk($sformatf("%s_wd%0d", t, i), wd[i], base + 32'(i));
         end
         if (i < ra.size()) begin
            chk($sformatf("%s_ra%0d", t, i), ra[i], 32'h8002_0000 + 32'(4 * i));
            chk($sformatf("%s_rc%0d", t, i), rc[i], i < nfull ? bcode : 32'd0);
         end
         if (i < outq.size()) chk($sformatf("%s_out%0d", t, i), outq[i], base + 32'(i));
      end
      chk({t, "_wl"}, 32'(words_loaded), 32'(n));
      chk({t, "_done_cnt"}, 32'(done_cnt), 32'd1);
   endtask

   task automatic chk_zero(input string t);
      chk({t, "_in_ready"}, 32'(in_ready), 0);
      chk({t, "_mem_en"}, 32'(mem_enable), 0);
      chk({t, "_mem_rw"}, 32'(mem_rw), 0);
      chk({t, "_addr"}, mem_address, 0);
      chk({t, "_size"}, 32'(mem_access_size), 0);
      chk({t, "_wdata"}, mem_data_in, 0);
      chk({t, "_out_valid"}, 32'(out_valid), 0);
      chk({t, "_out_data"}, out_data, 0);
      chk({t, "_done"}, 32'(done), 0);
      chk({t, "_wl"}, 32'(words_loaded), 0);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      chk_zero("rst");
      @(posedge clock); #2;
      reset_n = 1'b1;
      @(negedge clock);
      chk("post_rst_in_ready", 32'(in_ready), 0);
      chk("post_rst_done", 32'(done), 0);

      clear_log(); kick(2'b00); send(5, 32'hA500_0000); wait_done();
      check_run("t2", 5, 32'hA500_0000, 0, 0);

      clear_log(); kick(2'b01); send(10, 32'h1234_5600); wait_done();
      check_run("t3", 10, 32'h1234_5600, 1, 8);

      busy_rand = 1;
      clear_log(); kick(2'b10); send(12, 32'hC0DE_0100); wait_done();
      check_run("t4", 12, 32'hC0DE_0100, 2, 8);
      busy_rand = 0;

      out_ready = 1'b0;
      clear_log(); kick(2'b11); send(20, 32'h5A5A_0000);
      repeat (20) @(negedge clock);
      chk("t5_out_valid_held", 32'(out_valid), 1);
      chk("t5_reads_stalled", 32'(ra.size()), 2);
      chk("t5_max_outstanding", 32'(max_out), 2);
      @(posedge clock); #2;
      out_ready = 1'b1;
      wait_done();
      check_run("t5", 20, 32'h5A5A_0000, 3, 16);

      clear_log(); kick(2'b00); send(6, 32'hEEEE_0000);
      for (int k = 0; k < 100 && ra.size() < 2; k++) @(negedge clock);
      chk("t6_in_read", 32'(mem_rw), 1);
      #2 reset_n = 1'b0;
      #1 chk_zero("t6_abort");
      @(posedge clock); #2;
      reset_n = 1'b1;
      @(negedge clock);
      chk("t6_idle_in_ready", 32'(in_ready), 0);
      clear_log(); kick(2'b00); send(3, 32'h0BAD_C0DE); wait_done();
      check_run("t6", 3, 32'h0BAD_C0DE, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running exp finished");
      $fatal(1);
   end
endmodule
